// File: rtl/intercore_mailbox_arbiter.sv
// Round-robin arbiter sharing one intercore mailbox write port among
// g_num_cores message sources. A grant covers a whole burst (ended by last)
// and is force-released on reaching g_max_burst beats or after g_timeout
// consecutive idle cycles from the granted core.
module intercore_mailbox_arbiter #(
    parameter int unsigned g_num_cores  = 4,
    parameter int unsigned g_data_width = 32,
    parameter int unsigned g_max_burst  = 16,
    parameter int unsigned g_timeout    = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [g_num_cores-1:0]                s_valid,
    input  logic [g_num_cores*g_data_width-1:0]   s_data,
    input  logic [g_num_cores-1:0]                s_last,
    output logic [g_num_cores-1:0]                s_ready,
    output logic                                  m_valid,
    output logic [g_data_width-1:0]               m_data,
    output logic                                  m_last,
    output logic [$clog2(g_num_cores)-1:0]        m_src,
    input  logic                                  m_ready,
    output logic [g_num_cores-1:0]                grant,
    output logic                                  busy,
    output logic                                  trunc_err,
    output logic                                  timeout_err
);

    localparam int unsigned SRC_W  = $clog2(g_num_cores);
    localparam int unsigned BEAT_W = $clog2(g_max_burst + 1);
    localparam int unsigned IDLE_W = $clog2(g_timeout + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(g_max_burst - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(g_timeout - 1);
    localparam logic [SRC_W-1:0]  SRC_MAX   = SRC_W'(g_num_cores - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t state, state_next;

    logic [BEAT_W-1:0] beat_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [SRC_W-1:0]  rr_ptr;

    logic [g_num_cores-1:0][g_data_width-1:0] data_arr;

    logic             sel_found;
    logic [SRC_W-1:0] sel_idx;
    logic [SRC_W-1:0] cand;
    logic             g_valid;
    logic             g_last;
    logic             xfer;
    logic             at_max;
    logic             burst_end;
    logic             trunc_hit;
    logic             idle_hit;

    assign data_arr = s_data;

    // Round-robin pick: first requesting core at or above rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < g_num_cores; k++) begin
            cand = SRC_W'((32'(rr_ptr) + k) % g_num_cores);
            if (!sel_found && s_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Burst status of the granted core and the three release conditions.
    always_comb begin
        g_valid   = s_valid[m_src];
        g_last    = s_last[m_src];
        at_max    = (beat_cnt == BEAT_LAST);
        xfer      = (state == ST_GRANT) && g_valid && m_ready;
        burst_end = xfer && (g_last || at_max);
        trunc_hit = xfer && at_max && !g_last;
        idle_hit  = (state == ST_GRANT) && !g_valid && (idle_cnt == IDLE_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and granted-core pass-through outputs.
    always_comb begin
        state_next = state;
        s_ready    = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy           = 1'b1;
                m_valid        = g_valid;
                m_data         = data_arr[m_src];
                m_last         = g_last || at_max;
                s_ready[m_src] = m_ready;
                if (burst_end || idle_hit) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant, counters, round-robin pointer and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant       <= '0;
            m_src       <= '0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            rr_ptr      <= '0;
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    if (sel_found) begin
                        grant <= g_num_cores'(1) << sel_idx;
                        m_src <= sel_idx;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        idle_cnt <= '0;
                    end else if (!g_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end else begin
                        // Backpressure breaks a run of idle cycles.
                        idle_cnt <= '0;
                    end
                    if (burst_end || idle_hit) begin
                        grant <= '0;
                    end
                    trunc_err   <= trunc_hit;
                    timeout_err <= idle_hit;
                end
                ST_RELEASE: begin
                    grant    <= '0;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    rr_ptr   <= (m_src == SRC_MAX) ? '0 : m_src + 1'b1;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/intercore_mailbox_arbiter.md
Name: intercore_mailbox_arbiter

Overview:
- Round-robin arbiter that lets g_num_cores MicroBlaze-side message sources share one intercore mailbox write port.
- Grants one core at a time for a whole message (a burst terminated by last) and forwards its beats with a valid/ready handshake.
- Tags each beat with the source core index.
- Force-releases a core whose burst exceeds the limit or that stalls too long.

Parameters:
- g_num_cores, 4, number of requesting cores (2..8)
- g_data_width, 32, message beat width in bits
- g_max_burst, 16, maximum beats per grant before forced release (≥2)
- g_timeout, 255, consecutive cycles a granted core may hold s_valid low before forced release (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- s_valid  in  g_num_cores  per-core beat valid
- s_data  in  g_num_cores*g_data_width  per-core beat data; core i occupies bits [i*W +: W]
- s_last  in  g_num_cores  per-core end-of-message marker
- s_ready  out  g_num_cores  per-core beat accepted
- m_valid  out  1  beat valid toward the mailbox
- m_data  out  g_data_width  forwarded beat
- m_last  out  1  end of granted burst
- m_src  out  $clog2(g_num_cores)  index of the granted core
- m_ready  in  1  mailbox can accept a beat
- grant  out  g_num_cores  one-hot current grant; all zero when idle
- busy  out  1  grant active
- trunc_err  out  1  one-cycle pulse on forced release at g_max_burst
- timeout_err  out  1  one-cycle pulse on forced release by timeout

Behaviour:
- Reset (rst=0, asynchronous) clears state to IDLE, grant=0, beat_cnt=0, idle_cnt=0, rr_ptr=0, both error pulses=0. Output values while rst=0: m_valid=0, s_ready=0, busy=0, m_src=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any s_valid bit is set, select the first set bit searching from rr_ptr upward with wrap-around.
  - Register the selection into grant/m_src, go to GRANT.
  - Arbitration latency is 1 cycle: the first beat can transfer on the cycle after the request is seen.
- GRANT (g = granted index):
  - Combinational pass-through: m_valid=s_valid[g], m_data=s_data[g], s_ready[g]=m_ready, s_ready of all other cores = 0.
  - m_last = s_last[g] OR (beat_cnt == g_max_burst-1).
  - A beat transfers when m_valid & m_ready. On each transfer beat_cnt increments and idle_cnt clears.
  - While s_valid[g]=0, idle_cnt increments. Backpressure (s_valid=1, m_ready=0) does not count toward the timeout.
- Exits from GRANT (all go to RELEASE):
  - Transfer with s_last[g]=1: normal release.
  - Transfer with beat_cnt==g_max_burst-1 and s_last[g]=0: forced release, trunc_err pulses in the RELEASE cycle.
  - idle_cnt reaches g_timeout-1 with s_valid[g]=0: forced release, timeout_err pulses in the RELEASE cycle, no beat transferred in that cycle.
- Simultaneous last and max-burst on the same beat: treat as normal release, no trunc_err.
- RELEASE (1 cycle):
  - grant=0, m_valid=0, all s_ready=0, beat_cnt=0, idle_cnt=0.
  - rr_ptr = (g+1) mod g_num_cores.
  - Then go to IDLE. Back-to-back messages therefore have a minimum 2-cycle gap: RELEASE plus IDLE arbitration.
- Input stability: s_valid/s_data of non-granted cores are ignored and may change freely. A granted core must hold its data stable while s_valid=1 and ready=0.
- Fairness: a continuously requesting core is served within g_num_cores-1 other grants.
- Counters:
  - beat_cnt width $clog2(g_max_burst+1); idle_cnt width $clog2(g_timeout+1).
  - Neither counter wraps, because the state exits before overflow.
- Reset asserted mid-burst: the burst is aborted with no m_last. The source core retransmits the full message; that is the caller's responsibility.
- busy = (state==GRANT). grant is registered and never has more than one bit set.

Test Plan:
- Single requester: core 2 sends 3 beats 0xA0,0xA1,0xA2 with last on the third, m_ready=1 → grant=0b0100 one cycle after s_valid; m_src=2; three beats out in consecutive cycles with m_last on 0xA2; busy low 1 cycle later; no error pulses.
- Round-robin: all 4 cores request continuously with 1-beat messages → grants in order 0,1,2,3,0; each grant separated by a 2-cycle gap; after reset the first grant goes to core 0.
- Backpressure: core 1 sends 4 beats, m_ready toggles 1,0,0,1,... → data held while m_ready=0; exactly 4 transfers, in order; no timeout even when stalled for 300 cycles.
- Truncation: g_max_burst=16, core 3 sends 20 beats without last → m_last asserted on beat 16; trunc_err pulses once; the next grant goes to core 0 if it is requesting.
- Timeout: g_timeout=255, core 0 sends 1 beat without last, then drops s_valid → release after 255 idle cycles; timeout_err pulses once; grant=0.
- Reset mid-burst: assert rst=0 asynchronously during beat 2 of a 5-beat message from core 1 → m_valid, s_ready, grant and busy go low immediately without waiting for clk; after release the next grant starts from core 0.
